// File: rtl/toy_mem_arbiter.sv
// toy_mem_arbiter
//   Shares one single-port synchronous SRAM between the RISC_TOY instruction
//   fetch port and data port. Grants at most one access per cycle, stalls the
//   loser and steers the SRAM read data back to whichever port issued the read.
//
// Ports
//   CLK, RSTN                      clock (rising edge), async active-low reset
//   IREQ, IADDR                    fetch request / word address
//   INSTR, I_RVALID, I_STALL       fetch read data, data-valid pulse, stall
//   DREQ, DRW, DADDR, DWDATA       data request, 1=write, word address, wdata
//   DRDATA, D_RVALID, D_STALL      load data, data-valid pulse, stall
//   MCSN, MWEN, MADDR, MDI         SRAM chip select / write enable (active-low),
//                                  address, write data
//   MDOUT                          SRAM read data, one cycle after a read
//   STAT_CONFLICT, STAT_FORCED     (only with ARB_STATS_EN) saturating counts of
//                                  conflict cycles and starvation-forced fetches
//
// Build option
//   ARB_STATS_EN  adds the two statistics counters and their output ports.
module toy_mem_arbiter #(
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter int MAX_IWAIT = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IREQ,
  input  logic [AW-1:0] IADDR,
  output logic [DW-1:0] INSTR,
  output logic          I_RVALID,
  output logic          I_STALL,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [AW-1:0] DADDR,
  input  logic [DW-1:0] DWDATA,
  output logic [DW-1:0] DRDATA,
  output logic          D_RVALID,
  output logic          D_STALL,
  output logic          MCSN,
  output logic          MWEN,
  output logic [AW-1:0] MADDR,
  output logic [DW-1:0] MDI,
  input  logic [DW-1:0] MDOUT
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   STAT_CONFLICT,
  output logic [15:0]   STAT_FORCED
`endif
);

  localparam logic [3:0] MAX_W = 4'(MAX_IWAIT);

  logic [3:0]    iwait_q, iwait_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_owner_q, rsp_owner_d;  // 1 = data port, 0 = fetch port
  logic [DW-1:0] instr_q, drdata_q;
  logic [AW-1:0] maddr_q;
  logic [DW-1:0] mdi_q;

  logic forced;
  logic gnt_i;
  logic gnt_d;

  always_comb begin
    forced      = IREQ & (iwait_q == MAX_W);
    // Grants are qualified by RSTN so nothing reaches the SRAM while reset is
    // held, including a request that is already being presented.
    gnt_i       = RSTN & IREQ & (~DREQ | forced);
    gnt_d       = RSTN & DREQ & ~gnt_i;

    I_STALL     = RSTN & IREQ & ~gnt_i;
    D_STALL     = RSTN & DREQ & ~gnt_d;

    MCSN        = ~(gnt_i | gnt_d);
    MWEN        = ~(gnt_d & DRW);
    MADDR       = maddr_q;
    MDI         = mdi_q;
    if (gnt_i) begin
      MADDR = IADDR;
    end else if (gnt_d) begin
      MADDR = DADDR;
      MDI   = DWDATA;
    end

    // Starvation counter: only counts consecutive denied fetch cycles.
    iwait_d     = iwait_q;
    if (!IREQ || gnt_i) begin
      iwait_d = '0;
    end else if (iwait_q != MAX_W) begin
      iwait_d = iwait_q + 4'd1;
    end

    rsp_valid_d = gnt_i | (gnt_d & ~DRW);
    rsp_owner_d = gnt_d;

    I_RVALID    = rsp_valid_q & ~rsp_owner_q;
    D_RVALID    = rsp_valid_q &  rsp_owner_q;
    INSTR       = I_RVALID ? MDOUT : instr_q;
    DRDATA      = D_RVALID ? MDOUT : drdata_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      iwait_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      instr_q     <= '0;
      drdata_q    <= '0;
      maddr_q     <= '0;
      mdi_q       <= '0;
    end else begin
      iwait_q     <= iwait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      instr_q     <= INSTR;
      drdata_q    <= DRDATA;
      maddr_q     <= MADDR;
      mdi_q       <= MDI;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  logic [15:0] forced_q, forced_d;

  always_comb begin
    conflict_d = conflict_q;
    forced_d   = forced_q;
    if (IREQ && DREQ && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
    // Only a fetch that actually beat a pending data request was forced.
    if (gnt_i && DREQ && forced && forced_q != 16'hFFFF) begin
      forced_d = forced_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      conflict_q <= '0;
      forced_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      forced_q   <= forced_d;
    end
  end

  assign STAT_CONFLICT = conflict_q;
  assign STAT_FORCED   = forced_q;
`endif

endmodule

// File: tb/tb_toy_mem_arbiter.sv
module tb_toy_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        I_RVALID, I_STALL;
  logic        DREQ, DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        D_RVALID, D_STALL;
  logic        MCSN, MWEN;
  logic [29:0] MADDR;
  logic [31:0] MDI;
  logic [31:0] MDOUT;
`ifdef ARB_STATS_EN
  logic [15:0] STAT_CONFLICT, STAT_FORCED;
`endif

  toy_mem_arbiter #(.AW(30), .DW(32), .MAX_IWAIT(4)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR), .I_RVALID(I_RVALID), .I_STALL(I_STALL),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA),
    .D_RVALID(D_RVALID), .D_STALL(D_STALL),
    .MCSN(MCSN), .MWEN(MWEN), .MADDR(MADDR), .MDI(MDI), .MDOUT(MDOUT)
`ifdef ARB_STATS_EN
    , .STAT_CONFLICT(STAT_CONFLICT), .STAT_FORCED(STAT_FORCED)
`endif
  );

  always #5 CLK = ~CLK;

  // SRAM macro model (256 words visible)
  logic [31:0] sram [256];
  always @(posedge CLK) begin
    if (!MCSN) begin
      if (!MWEN) sram[MADDR[7:0]] <= MDI;
      else       MDOUT <= sram[MADDR[7:0]];
    end
  end

  // Bench-side reference memory for expected read data
  logic [31:0] ref_mem [256];

  typedef struct {
    logic        ireq;
    logic [29:0] iaddr;
    logic        dreq;
    logic        drw;
    logic [29:0] daddr;
    logic [31:0] dwdata;
    logic        istall;
    logic        dstall;
    logic        mcsn;
    logic        mwen;
    logic [29:0] maddr;
  } vec_t;

  typedef struct {
    logic        own_d;
    logic [31:0] data;
  } rsp_t;

  vec_t  vecs[$];
  rsp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  int    n_conf = 0;
  int    n_forced = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ireq, input logic [29:0] iaddr, input logic dreq,
                              input logic drw, input logic [29:0] daddr, input logic [31:0] dwdata,
                              input logic istall, input logic dstall, input logic mcsn,
                              input logic mwen, input logic [29:0] maddr);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.drw = drw; v.daddr = daddr;
    v.dwdata = dwdata; v.istall = istall; v.dstall = dstall; v.mcsn = mcsn;
    v.mwen = mwen; v.maddr = maddr;
    return v;
  endfunction

  // Compare response outputs one edge after issue against the scoreboard.
  task automatic check_rsp(input bit pushed);
    rsp_t e;
    logic exp_iv, exp_dv;
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    if (pushed) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.own_d) begin exp_dv = 1'b1; last_d = e.data; end
        else         begin exp_iv = 1'b1; last_i = e.data; end
      end
    end
    chk("I_RVALID", 32'(I_RVALID), 32'(exp_iv));
    chk("D_RVALID", 32'(D_RVALID), 32'(exp_dv));
    chk("INSTR", INSTR, last_i);
    chk("DRDATA", DRDATA, last_d);
  endtask

  task automatic step(input vec_t v);
    bit   pushed;
    rsp_t r;
    @(negedge CLK);
    IREQ = v.ireq; IADDR = v.iaddr; DREQ = v.dreq; DRW = v.drw;
    DADDR = v.daddr; DWDATA = v.dwdata;
    #2;
    chk("I_STALL", 32'(I_STALL), 32'(v.istall));
    chk("D_STALL", 32'(D_STALL), 32'(v.dstall));
    chk("MCSN", 32'(MCSN), 32'(v.mcsn));
    chk("MWEN", 32'(MWEN), 32'(v.mwen));
    chk("MADDR", 32'(MADDR), 32'(v.maddr));
    pushed = 1'b0;
    if (!v.mcsn && !v.mwen) begin
      chk("MDI", MDI, v.dwdata);
      ref_mem[v.maddr[7:0]] = v.dwdata;
    end
    if (!v.mcsn && v.mwen) begin
      r.own_d = !(v.ireq && !v.istall);
      r.data  = ref_mem[v.maddr[7:0]];
      sb.push_back(r);
      pushed = 1'b1;
    end
    if (v.ireq && v.dreq) begin
      n_conf++;
      if (!v.istall) n_forced++;
    end
    @(posedge CLK);
    #1;
    check_rsp(pushed);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 32'h100 + i;
      ref_mem[i] = 32'h100 + i;
    end
    sram[8'h10]    = 32'hCAFE;
    ref_mem[8'h10] = 32'hCAFE;
    MDOUT = '0;

    // Fetch-only stream, addresses 0..7 back-to-back
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 30'(i), 0, 0, 0, 0, 0, 0, 0, 1, 30'(i)));
    // Simultaneous read: data wins, fetch granted the following cycle
    vecs.push_back(mk(1, 8, 1, 0, 30'h10, 0, 1, 0, 0, 1, 30'h10));
    vecs.push_back(mk(1, 8, 0, 0, 0,      0, 0, 0, 0, 1, 8));
    // Write then read of the same address
    vecs.push_back(mk(0, 0, 1, 1, 30'h20, 32'h1234, 0, 0, 0, 0, 30'h20));
    vecs.push_back(mk(0, 0, 1, 0, 30'h20, 0,        0, 0, 0, 1, 30'h20));
    // Idle: SRAM deselected, address holds
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 30'h20));
    // Starvation: four denials, fifth cycle forced, counter then restarts
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 3, 1, 0, 30'h10, 0, 1, 0, 0, 1, 30'h10));
    vecs.push_back(mk(1, 3, 1, 0, 30'h10, 0, 0, 1, 0, 1, 3));
    vecs.push_back(mk(1, 3, 1, 0, 30'h10, 0, 1, 0, 0, 1, 30'h10));
    vecs.push_back(mk(1, 3, 0, 0, 0,      0, 0, 0, 0, 1, 3));
    // Fetch dropped while stalled clears the wait count
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 4, 1, 0, 30'h11, 0, 1, 0, 0, 1, 30'h11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 30'h11));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 4, 1, 0, 30'h11, 0, 1, 0, 0, 1, 30'h11));
    vecs.push_back(mk(1, 4, 1, 0, 30'h11, 0, 0, 1, 0, 1, 4));
    // Write beating a fetch, then fetch, then read back the write
    vecs.push_back(mk(1, 5, 1, 1, 30'h30, 32'hBEEF, 1, 0, 0, 0, 30'h30));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0,             0, 0, 0, 1, 5));
    vecs.push_back(mk(0, 0, 1, 0, 30'h30, 0,        0, 0, 0, 1, 30'h30));

    // Reset state, with a fetch request present during reset
    RSTN = 1'b0; IREQ = 1'b1; IADDR = 30'h7; DREQ = 1'b0; DRW = 1'b0;
    DADDR = '0; DWDATA = '0;
    #12;
    chk("rst_MCSN", 32'(MCSN), 32'd1);
    chk("rst_MWEN", 32'(MWEN), 32'd1);
    chk("rst_I_STALL", 32'(I_STALL), 32'd0);
    chk("rst_I_RVALID", 32'(I_RVALID), 32'd0);
    chk("rst_INSTR", INSTR, 32'd0);
    chk("rst_DRDATA", DRDATA, 32'd0);
    chk("rst_MADDR", 32'(MADDR), 32'd0);
    chk("rst_MDI", MDI, 32'd0);
    IREQ = 1'b0;
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_I_RVALID", 32'(I_RVALID), 32'd0);
    chk("post_rst_D_RVALID", 32'(D_RVALID), 32'd0);

    foreach (vecs[k]) step(vecs[k]);

`ifdef ARB_STATS_EN
    chk("STAT_CONFLICT", 32'(STAT_CONFLICT), 32'(n_conf));
    chk("STAT_FORCED", 32'(STAT_FORCED), 32'(n_forced));
`endif

    // Reset asserted between issuing a fetch read and its return edge
    @(negedge CLK);
    IREQ = 1'b1; IADDR = 30'h5; DREQ = 1'b0;
    #2;
    chk("midrst_issue_MCSN", 32'(MCSN), 32'd0);
    #1;
    RSTN = 1'b0;
    #1;
    chk("midrst_MCSN", 32'(MCSN), 32'd1);
    chk("midrst_I_STALL", 32'(I_STALL), 32'd0);
    @(posedge CLK);
    #1;
    chk("midrst_I_RVALID", 32'(I_RVALID), 32'd0);
    chk("midrst_INSTR", INSTR, 32'd0);
    chk("midrst_DRDATA", DRDATA, 32'd0);
    chk("midrst_MADDR", 32'(MADDR), 32'd0);
    @(negedge CLK);
    IREQ = 1'b0;
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_rel_I_RVALID", 32'(I_RVALID), 32'd0);
    last_i = '0;
    last_d = '0;
    sb.delete();
    step(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
